// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin arbiter sharing one logical-right barrel shifter.
// The result goes to a single tagged, one-deep output register with valid/ready backpressure.
module shift_req_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter bit          RR_INIT = 1'b0,
    localparam int unsigned AMT_W  = 3,
    localparam int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_tag,
    output logic [CNT_W-1:0]  busy_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tag_q, tag_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              can_accept;
    logic              gnt0, gnt1;
    logic              xfer0, xfer1;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic [DATA_W-1:0] shifted;

    // Arbitration depends only on valids and the pointer, never on operands.
    always_comb begin
        can_accept = (state_q == EMPTY) | res_ready;
        gnt0       = req0_valid & (~req1_valid | (ptr_q == 1'b0));
        gnt1       = req1_valid & (~req0_valid | (ptr_q == 1'b1));
        req0_ready = gnt0 & can_accept & rst_n;
        req1_ready = gnt1 & can_accept & rst_n;
        xfer0      = req0_valid & req0_ready;
        xfer1      = req1_valid & req1_ready;
        sel_data   = xfer1 ? req1_data : req0_data;
        sel_amt    = xfer1 ? req1_amt  : req0_amt;
        shifted    = sel_data >> sel_amt;
    end

    // Next-state: load on transfer, drain on accept without transfer, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (xfer0 | xfer1) begin
            state_d = FULL;
            data_d  = shifted;
            tag_d   = xfer1;
            ptr_d   = ~xfer1;
        end else if ((state_q == FULL) & res_ready) begin
            state_d = EMPTY;
        end

        if ((req0_valid | req1_valid) & ~can_accept & (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            tag_q   <= 1'b0;
            ptr_q   <= RR_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = data_q;
    assign res_tag   = tag_q;
    assign busy_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Bench for shift_req_arbiter: directed vector table, multi-cycle corner sequences,
// and constrained-random traffic checked against a behavioural round-robin model.
module tb_shift_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_amt, req1_amt;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_tag;
    logic [7:0] busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    shift_req_arbiter #(.DATA_W(8), .RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic [2:0] a0;
        logic       v1;
        logic [7:0] d1;
        logic [2:0] a1;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_t;
        logic [7:0] e_b;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [7:0] d0, input logic [2:0] a0,
                         input logic v1, input logic [7:0] d1, input logic [2:0] a1, input logic rr);
        rst_n = rst; req0_valid = v0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_data = d1; req1_amt = a1; res_ready = rr;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: round-robin search from the priority holder, one-deep result slot.
    logic       m_full;
    logic [7:0] m_data;
    logic       m_tag;
    int         m_prio;
    int         m_busy;
    int         m_win;

    task automatic model_reset();
        m_full = 1'b0; m_data = 8'h00; m_tag = 1'b0; m_prio = 0; m_busy = 0; m_win = -1;
    endtask

    task automatic model_pick(input logic rst, input logic v0, input logic v1, input logic rr);
        logic vv[2];
        int   idx;
        vv[0] = v0; vv[1] = v1;
        m_win = -1;
        if (rst && (!m_full || rr)) begin
            for (int k = 0; k < 2; k++) begin
                idx = (m_prio + k) % 2;
                if (vv[idx] && m_win < 0) m_win = idx;
            end
        end
    endtask

    task automatic model_edge(input logic rst, input logic v0, input logic [7:0] d0, input logic [2:0] a0,
                              input logic v1, input logic [7:0] d1, input logic [2:0] a1, input logic rr);
        int opnd, sh;
        if (!rst) begin
            model_reset();
        end else begin
            if ((v0 || v1) && m_full && !rr && m_busy < 255) m_busy++;
            if (m_win >= 0) begin
                opnd   = (m_win == 0) ? int'(d0) : int'(d1);
                sh     = (m_win == 0) ? int'(a0) : int'(a1);
                m_data = 8'(opnd / (1 << sh));
                m_tag  = (m_win == 1);
                m_full = 1'b1;
                m_prio = 1 - m_win;
            end else if (m_full && rr) begin
                m_full = 1'b0;
            end
        end
    endtask

    initial begin
        // rst v0 d0 a0 v1 d1 a1 rr | r0 r1 v d t busy
        tbl[0]  = '{1'b0, 1'b1, 8'hB4, 3'd3, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'hB4, 3'd3, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h16, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h80, 3'd7, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'd2};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'd3};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'd4};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'd5};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 8'd5};
        tbl[16] = '{1'b1, 1'b1, 8'h56, 3'd1, 1'b1, 8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b1, 8'd6};
        tbl[17] = '{1'b1, 1'b1, 8'h56, 3'd1, 1'b1, 8'h33, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h2B, 1'b0, 8'd6};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B, 1'b0, 8'd6};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2B, 1'b0, 8'd6};

        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();

        // Directed vectors: readies checked before the edge, registered outputs after it.
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].a0, tbl[i].v1, tbl[i].d1, tbl[i].a1, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d req0_ready", i), req0_ready, tbl[i].e_r0);
            chk($sformatf("vec%0d req1_ready", i), req1_ready, tbl[i].e_r1);
            tick();
            chk($sformatf("vec%0d res_valid", i), res_valid, tbl[i].e_v);
            chk($sformatf("vec%0d res_data", i), res_data, tbl[i].e_d);
            chk($sformatf("vec%0d res_tag", i), res_tag, tbl[i].e_t);
            chk($sformatf("vec%0d busy_cnt", i), busy_cnt, tbl[i].e_b);
        end

        // Saturation: fill the slot, then stall 300 cycles with req0 pending.
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hC3, 3'd2, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        chk("sat fill res_data", res_data, 8'h30);
        drive(1'b1, 1'b1, 8'h11, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 300; c++) tick();
        chk("sat busy_cnt 300", busy_cnt, 8'd255);
        for (int c = 0; c < 5; c++) tick();
        chk("sat busy_cnt hold", busy_cnt, 8'd255);
        chk("sat res_data stable", res_data, 8'h30);
        chk("sat req0_ready low", req0_ready, 1'b0);

        // Reset mid-operation: slot full from req0 (pointer now at req1), then reset one cycle.
        drive(1'b0, 1'b1, 8'h11, 3'd0, 1'b1, 8'h22, 3'd0, 1'b0);
        tick();
        chk("midrst res_valid", res_valid, 1'b0);
        chk("midrst res_data", res_data, 8'h00);
        chk("midrst busy_cnt", busy_cnt, 8'd0);
        drive(1'b1, 1'b1, 8'h11, 3'd0, 1'b1, 8'h22, 3'd0, 1'b1);
        #1;
        chk("midrst grant req0", req0_ready, 1'b1);
        chk("midrst no req1", req1_ready, 1'b0);
        tick();
        chk("midrst new tag", res_tag, 1'b0);
        chk("midrst new data", res_data, 8'h11);

        // Random traffic against the model; requesters hold operands until accepted.
        begin
            logic       rst, v0, v1, rr;
            logic [7:0] d0, d1;
            logic [2:0] a0, a1;
            logic       r0, r1;
            v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; a0 = 3'd0; a1 = 3'd0;
            drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
            tick();
            model_reset();
            for (int c = 0; c < 2000; c++) begin
                rst = ($urandom_range(63) != 0);
                if (!v0) begin
                    v0 = ($urandom_range(3) != 0); d0 = 8'($urandom); a0 = 3'($urandom);
                end
                if (!v1) begin
                    v1 = ($urandom_range(3) != 0); d1 = 8'($urandom); a1 = 3'($urandom);
                end
                rr = ($urandom_range(3) != 0);
                drive(rst, v0, d0, a0, v1, d1, a1, rr);
                model_pick(rst, v0, v1, rr);
                #1;
                r0 = req0_ready; r1 = req1_ready;
                chk("rnd req0_ready", r0, (m_win == 0));
                chk("rnd req1_ready", r1, (m_win == 1));
                model_edge(rst, v0, d0, a0, v1, d1, a1, rr);
                tick();
                chk("rnd res_valid", res_valid, m_full);
                chk("rnd res_data", res_data, m_data);
                chk("rnd res_tag", res_tag, m_tag);
                chk("rnd busy_cnt", busy_cnt, 8'(m_busy));
                if (m_win == 0 || !rst) v0 = 1'b0;
                if (m_win == 1 || !rst) v1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
